// File: rtl/opcode_type.sv
// Shared decode types: instruction kinds, immediate formats, decoded entry.
// No timing; purely declarations plus one immediate-assembly helper.
// No flow control here; consumers own their handshakes.
package opcode_type;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, FENCE_I, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        ILLEGAL
    } instr_kind_t;

    typedef enum logic [2:0] {R, I, S, B, U, J} imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // One decoded instruction as it sits in the output or skid register.
    typedef struct packed {
        instr_kind_t kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } dec_entry_t;

    localparam dec_entry_t ENTRY_RESET = '{
        kind:    ILLEGAL,
        rd:      5'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        imm:     32'd0,
        pc:      32'd0,
        illegal: 1'b0
    };

    // Assemble the sign-extended immediate for a given encoding format.
    function automatic logic [31:0] imm_from_fmt(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            I:       imm = {{20{instr[31]}}, instr[31:20]};
            S:       imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B:       imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            U:       imm = {instr[31:12], 12'h000};
            J:       imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I(+M) decoder: kind, register indices, immediate, illegal flag.
// Zero latency.
// No flow control; outputs follow instr directly.
module decode_comb
    import opcode_type::*;
#(
    parameter int unsigned ENABLE_M = 0
) (
    input  logic [31:0] instr,
    output instr_kind_t kind,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_fmt_t   fmt;
    logic       is_shift_imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Index fields are passed through raw even for formats that do not use them.
    assign rd  = instr[11:7];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    // Classify the instruction; anything not explicitly recognised stays ILLEGAL.
    always_comb begin
        kind         = ILLEGAL;
        fmt          = R;
        is_shift_imm = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fmt  = U;
                kind = LUI;
            end
            OPC_AUIPC: begin
                fmt  = U;
                kind = AUIPC;
            end
            OPC_JAL: begin
                fmt  = J;
                kind = JAL;
            end
            OPC_JALR: begin
                fmt = I;
                if (funct3 == 3'b000) kind = JALR;
            end
            OPC_BRANCH: begin
                fmt = B;
                case (funct3)
                    3'b000:  kind = BEQ;
                    3'b001:  kind = BNE;
                    3'b100:  kind = BLT;
                    3'b101:  kind = BGE;
                    3'b110:  kind = BLTU;
                    3'b111:  kind = BGEU;
                    default: kind = ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = I;
                case (funct3)
                    3'b000:  kind = LB;
                    3'b001:  kind = LH;
                    3'b010:  kind = LW;
                    3'b100:  kind = LBU;
                    3'b101:  kind = LHU;
                    default: kind = ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = S;
                case (funct3)
                    3'b000:  kind = SB;
                    3'b001:  kind = SH;
                    3'b010:  kind = SW;
                    default: kind = ILLEGAL;
                endcase
            end
            OPC_OPIMM: begin
                fmt = I;
                case (funct3)
                    3'b000: kind = ADDI;
                    3'b010: kind = SLTI;
                    3'b011: kind = SLTIU;
                    3'b100: kind = XORI;
                    3'b110: kind = ORI;
                    3'b111: kind = ANDI;
                    3'b001: begin
                        is_shift_imm = 1'b1;
                        if (funct7 == F7_BASE) kind = SLLI;
                    end
                    default: begin
                        // funct3 101: logical vs arithmetic selected by instr[30]
                        is_shift_imm = 1'b1;
                        if (funct7 == F7_BASE)     kind = SRLI;
                        else if (funct7 == F7_ALT) kind = SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                fmt = R;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  kind = ADD;
                        3'b001:  kind = SLL;
                        3'b010:  kind = SLT;
                        3'b011:  kind = SLTU;
                        3'b100:  kind = XOR;
                        3'b101:  kind = SRL;
                        3'b110:  kind = OR;
                        default: kind = AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      kind = SUB;
                    else if (funct3 == 3'b101) kind = SRA;
                end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
                    case (funct3)
                        3'b000:  kind = MUL;
                        3'b001:  kind = MULH;
                        3'b010:  kind = MULHSU;
                        3'b011:  kind = MULHU;
                        3'b100:  kind = DIV;
                        3'b101:  kind = DIVU;
                        3'b110:  kind = REM;
                        default: kind = REMU;
                    endcase
                end
            end
            OPC_FENCE: begin
                fmt = I;
                if (funct3 == 3'b000)      kind = FENCE;
                else if (funct3 == 3'b001) kind = FENCE_I;
            end
            OPC_SYSTEM: begin
                fmt = I;
                case (funct3)
                    3'b000: begin
                        if (instr == 32'h0000_0073)      kind = ECALL;
                        else if (instr == 32'h0010_0073) kind = EBREAK;
                    end
                    3'b001:  kind = CSRRW;
                    3'b010:  kind = CSRRS;
                    3'b011:  kind = CSRRC;
                    3'b101:  kind = CSRRWI;
                    3'b110:  kind = CSRRSI;
                    3'b111:  kind = CSRRCI;
                    default: kind = ILLEGAL;
                endcase
            end
            default: begin
                kind = ILLEGAL;
                fmt  = R;
            end
        endcase
    end

    // Shift-immediates carry a zero-extended shamt, not the sign-extended I field.
    always_comb begin
        if (is_shift_imm) imm = {27'd0, instr[24:20]};
        else              imm = imm_from_fmt(instr, fmt);
    end

    assign illegal = (kind == ILLEGAL);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registered decoded entry with optional two-entry skid buffer.
// One cycle from input accept to output valid when the output register is free or draining.
// SKID=1: in_ready from a register, full throughput; SKID=0: in_ready follows the output register.
module decode_stage
    import opcode_type::*;
#(
    parameter int unsigned ENABLE_M = 0,
    parameter int unsigned SKID     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output instr_kind_t out_kind,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    instr_kind_t dec_kind;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    dec_entry_t  in_entry;
    dec_entry_t  out_q;
    dec_entry_t  skid_q;
    logic        skid_valid;
    logic        out_free;
    logic        accept;

    decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode_comb (
        .instr   (in_instr),
        .kind    (dec_kind),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign in_entry = '{
        kind:    dec_kind,
        rd:      dec_rd,
        rs1:     dec_rs1,
        rs2:     dec_rs2,
        imm:     dec_imm,
        pc:      in_pc,
        illegal: dec_illegal
    };

    // Output register can take a new entry this edge if it is empty or being consumed.
    assign out_free = !out_valid || out_ready;

    // With a skid slot, ready depends only on stored state, breaking the out_ready->in_ready path.
    assign in_ready = (SKID != 0) ? !skid_valid : out_free;
    assign accept   = in_valid && in_ready && !flush;

    // Output and skid registers; flush dominates both accept and output transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= ENTRY_RESET;
            skid_q     <= ENTRY_RESET;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // Older skid entry goes first; in_ready was low so nothing new arrives.
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= in_entry;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept && SKID != 0) begin
            // Output stalled: park the new entry behind it.
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_kind    = out_q.kind;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_imm     = out_q.imm;
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.illegal;

endmodule
